// File: rtl/dmem_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int WORD_W      = 16;
  localparam int DEF_LATENCY = 3;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_AW      = 8;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array: write and registered read on the same index; rst clears every word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Read returns the pre-write contents; the responder never reads and writes in one access.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[idx] <= wdata;
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store target: one request per handshake, response pulse LATENCY edges after acceptance, req_ready low until then.
// Optional DMEM_ALIGN_CHECK_EN flags odd byte addresses with resp_err and suppresses their access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = DEF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [15:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end
  if (DEPTH != (1 << AW)) begin : g_bad_depth
    $error("dmem_responder: DEPTH must equal 2**AW");
  end

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               cap_wr;
  logic               cap_mis;
  logic [AW-1:0]      cap_idx;
  logic [WORD_W-1:0]  cap_wdata;
  logic               addr_mis;
  logic               accept;
  logic               commit;
  logic               arr_we;
  logic [WORD_W-1:0]  arr_rdata;
  logic               unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_mis    = req_addr[0];
  assign unused_addr = ^req_addr[15:AW+1];
`else
  assign addr_mis    = 1'b0;
  assign unused_addr = ^{req_addr[15:AW+1], req_addr[0]};
`endif

  assign accept = (state == IDLE) && req_valid;
  // The edge leaving the last WAIT cycle is E0+LATENCY: the array access happens there.
  assign commit = (state == WAIT) && (cnt == '0);
  assign arr_we = commit && cap_wr && !cap_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_wr    <= 1'b0;
      cap_mis   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_wr    <= req_wr;
        cap_mis   <= addr_mis;
        cap_idx   <= req_addr[AW:1];
        cap_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .idx   (cap_idx),
    .wdata (cap_wdata),
    .rdata (arr_rdata)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && cap_mis;
  assign resp_rdata = (resp_valid && !cap_wr && !cap_mis) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a word-array model scores every response, timing and handshake rule.
module tb_dmem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain word memory plus a queue of accepted requests.
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          cyc;
  } req_t;

  logic [15:0] mdl [DEPTH];
  req_t        pend [$];
  int          cyc = 0;
  int          last_acc = -100;
  bit          b2b = 0;
  bit          chk_after_resp = 0;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  always @(negedge clk) begin
    req_t        r;
    int          widx;
    bit          mis;
    logic [15:0] exp_rd;
    cyc = cyc + 1;
    if (chk_after_resp) begin
      check("idle_ready_after_resp", req_ready, 1);
      check("resp_pulse_width", resp_valid, 0);
      chk_after_resp = 0;
    end
    if (rst) begin
      pend.delete();
      foreach (mdl[i]) mdl[i] = '0;
      last_acc = -100;
    end else begin
      check("ready_resp_exclusive", resp_valid & req_ready, 0);
      if (pend.size() != 0 && !resp_valid) check("busy_ready", req_ready, 0);
      if (resp_valid) begin
        check("resp_has_request", pend.size(), 1);
        if (pend.size() != 0) begin
          r    = pend.pop_front();
          widx = (int'(r.addr) / 2) % DEPTH;
          mis  = ALIGN_EN && r.addr[0];
          if (r.wr) begin
            exp_rd = '0;
            if (!mis) mdl[widx] = r.wdata;
          end else begin
            exp_rd = mis ? 16'h0000 : mdl[widx];
          end
          // Visible one negedge after entry edge E0+LAT; r.cyc is the negedge just before E0.
          check("resp_latency", cyc - r.cyc, LAT + 1);
          check("resp_rdata", resp_rdata, exp_rd);
          check("resp_err", resp_err, mis);
          chk_after_resp = 1;
        end
      end
      if (req_ready && req_valid) begin
        if (b2b) check("b2b_accept_gap", cyc - last_acc, LAT + 2);
        else     check("accept_gap_min", (cyc - last_acc) >= LAT + 2, 1);
        r.wr = req_wr; r.addr = req_addr; r.wdata = req_wdata; r.cyc = cyc;
        pend.push_back(r);
        last_acc = cyc;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata, input bit keep);
    bit got = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    check("accept_timeout", got, 1);
    @(posedge clk); #1;
    if (!keep) begin
      req_valid = 1'b0;
      req_wr    = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (pend.size() == 0 && req_ready) done = 1;
    end
    check("drain_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    @(posedge clk); #1;

    // Load from a freshly cleared array.
    issue(1'b0, 16'h0010, 16'h0000, 0);
    wait_idle();

    // Store then load with req_valid held: load taken right after the store's response.
    issue(1'b1, 16'h0020, 16'hBEEF, 1);
    b2b = 1;
    issue(1'b0, 16'h0020, 16'h0000, 0);
    b2b = 0;
    wait_idle();

    // Inputs changed while the store is in flight must not matter.
    issue(1'b1, 16'h0002, 16'h1234, 0);
    req_wr = 1'b1; req_addr = 16'h0004; req_wdata = 16'hFFFF;
    wait_idle();
    issue(1'b0, 16'h0002, 16'h0000, 0);
    issue(1'b0, 16'h0004, 16'h0000, 0);
    wait_idle();

    // Continuous requests alternating store/load.
    issue(1'b1, 16'h0100, 16'($urandom), 1);
    b2b = 1;
    for (int k = 1; k < 10; k++) begin
      a = 16'h0100 + 16'((k / 2) * 2);
      issue(1'(k % 2 == 0), a, 16'($urandom), k != 9);
    end
    b2b = 0;
    wait_idle();

    // Reset while a store is waiting: aborted, array cleared.
    issue(1'b1, 16'h0030, 16'hAAAA, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    issue(1'b0, 16'h0030, 16'h0000, 0);
    issue(1'b0, 16'h0020, 16'h0000, 0);
    wait_idle();

    // Odd address store, then the even word.
    issue(1'b1, 16'h0041, 16'h5555, 0);
    issue(1'b0, 16'h0040, 16'h0000, 0);
    wait_idle();

    // Random traffic on a small, aliased address window.
    for (int k = 0; k < 60; k++) begin
      a = 16'(($urandom_range(0, 127) << 9) | ($urandom_range(0, 7) << 1) | ($urandom_range(0, 3) == 0));
      issue(1'($urandom), a, 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
